// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage of the 16-bit CPU. Owns the PC (FetchAddr),
//   issues requests to instruction memory, handles branch redirects and
//   hazard stalls, and holds the IF/ID pipeline register that feeds the
//   control-unit decoder.
//
// Ports
//   Clock         in   system clock, rising edge
//   Reset_n       in   asynchronous active-low reset
//   IMemReq       out  fetch request (registered), held until IMemAck
//   IMemAddr      out  fetch address (registered), stable while IMemReq=1
//   IMemAck       in   memory returns IMemData this cycle
//   IMemData      in   instruction word, valid with IMemAck
//   Stall         in   hazard: hold IF/ID, accept no new instruction
//   BranchTaken   in   redirect / flush request
//   BranchTarget  in   redirect address (bit 0 forced to 0)
//   InstrValid    out  IF/ID holds a live instruction
//   Instruction   out  IF/ID instruction register
//   OPCODE        out  Instruction[15:12]
//   PcPlus2       out  address of the IF/ID instruction + 2
//   dbg_state     out  current FSM state (S_IDLE=0, S_REQ=1, S_DROP=2, S_HOLD=3)
//
// Handshake: a transfer happens on a rising edge where IMemReq=1 and
// IMemAck=1. Once raised, IMemReq and IMemAddr stay constant until that
// edge. IMemAck while IMemReq=0 has no effect.
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter int                    PC_WIDTH    = 16,
    parameter int                    INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0]   RESET_PC    = '0
) (
    input  logic                   Clock,
    input  logic                   Reset_n,
    output logic                   IMemReq,
    output logic [PC_WIDTH-1:0]    IMemAddr,
    input  logic                   IMemAck,
    input  logic [INSTR_WIDTH-1:0] IMemData,
    input  logic                   Stall,
    input  logic                   BranchTaken,
    input  logic [PC_WIDTH-1:0]    BranchTarget,
    output logic                   InstrValid,
    output logic [INSTR_WIDTH-1:0] Instruction,
    output logic [3:0]             OPCODE,
    output logic [PC_WIDTH-1:0]    PcPlus2,
    output logic [1:0]             dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DROP = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t                 state, state_d;
    logic [PC_WIDTH-1:0]    fetch_addr, fetch_addr_d;
    logic [PC_WIDTH-1:0]    addr_d;
    logic                   req_d;
    logic                   valid_d;
    logic [INSTR_WIDTH-1:0] instr_d;
    logic [PC_WIDTH-1:0]    pc_plus2_d;
    logic [INSTR_WIDTH-1:0] skid_data, skid_data_d;
    logic [PC_WIDTH-1:0]    fetch_inc;
    logic [PC_WIDTH-1:0]    target;

    assign fetch_inc = fetch_addr + PC_WIDTH'(2);   // wraps mod 2^PC_WIDTH
    assign target    = BranchTarget & ~PC_WIDTH'(1);
    assign OPCODE    = Instruction[INSTR_WIDTH-1 -: 4];
    assign dbg_state = state;

    // State register
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) state <= S_IDLE;
        else          state <= state_d;
    end

    // Next-state logic; priority is BranchTaken > Stall > IMemAck
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (BranchTaken)  state_d = IMemAck ? S_REQ : S_DROP;
                else if (IMemAck) state_d = Stall ? S_HOLD : S_REQ;
            end
            // The outstanding request must complete before redirecting
            S_DROP: if (IMemAck) state_d = S_REQ;
            S_HOLD: if (BranchTaken || !Stall) state_d = S_REQ;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        fetch_addr_d = fetch_addr;
        valid_d      = InstrValid;
        instr_d      = Instruction;
        pc_plus2_d   = PcPlus2;
        skid_data_d  = skid_data;
        case (state)
            S_REQ: begin
                if (BranchTaken) begin
                    valid_d      = 1'b0;
                    fetch_addr_d = target;
                end else if (IMemAck) begin
                    fetch_addr_d = fetch_inc;
                    if (Stall) begin
                        skid_data_d = IMemData;
                    end else begin
                        instr_d    = IMemData;
                        valid_d    = 1'b1;
                        pc_plus2_d = fetch_inc;
                    end
                end else if (!Stall) begin
                    valid_d = 1'b0;
                end
            end
            S_DROP: begin
                valid_d = 1'b0;
                if (BranchTaken) fetch_addr_d = target;
            end
            S_HOLD: begin
                if (BranchTaken) begin
                    valid_d      = 1'b0;
                    fetch_addr_d = target;
                    skid_data_d  = '0;
                end else if (!Stall) begin
                    // fetch_addr already advanced past the skid entry,
                    // so it equals the skid instruction's address + 2.
                    instr_d     = skid_data;
                    valid_d     = 1'b1;
                    pc_plus2_d  = fetch_addr;
                    skid_data_d = '0;
                end
            end
            default: ;
        endcase
        req_d  = (state_d == S_REQ) || (state_d == S_DROP);
        // S_DROP keeps the stale address on the bus until its ack arrives
        addr_d = (state_d == S_REQ) ? fetch_addr_d : IMemAddr;
    end

    // Datapath registers
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            fetch_addr  <= RESET_PC;
            IMemReq     <= 1'b0;
            IMemAddr    <= RESET_PC;
            InstrValid  <= 1'b0;
            Instruction <= '0;
            PcPlus2     <= '0;
            skid_data   <= '0;
        end else begin
            fetch_addr  <= fetch_addr_d;
            IMemReq     <= req_d;
            IMemAddr    <= addr_d;
            InstrValid  <= valid_d;
            Instruction <= instr_d;
            PcPlus2     <= pc_plus2_d;
            skid_data   <= skid_data_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//   Directed bench for fetch_stage. Two instances: the default RESET_PC and
//   RESET_PC=16'hFFFE (address wrap). A small table-driven memory answers
//   requests, either immediately (zero-wait) or under manual control.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    localparam int W = 16;

    // ---------------- clock / reset ----------------
    logic Clock = 1'b0;
    logic Reset_n;
    always #5 Clock = ~Clock;

    // ---------------- DUT 0 (RESET_PC = 0) ----------------
    logic          req0, ack0, stall, branch, valid0;
    logic [W-1:0]  addr0, data0, target, instr0, pc2_0;
    logic [3:0]    opc0;
    logic [1:0]    st0;
    logic          mem_auto, ack_man;

    assign ack0  = mem_auto ? req0 : ack_man;
    assign data0 = mem_word(addr0);

    fetch_stage #(.PC_WIDTH(W), .INSTR_WIDTH(W), .RESET_PC(16'h0000)) dut (
        .Clock(Clock), .Reset_n(Reset_n),
        .IMemReq(req0), .IMemAddr(addr0), .IMemAck(ack0), .IMemData(data0),
        .Stall(stall), .BranchTaken(branch), .BranchTarget(target),
        .InstrValid(valid0), .Instruction(instr0), .OPCODE(opc0),
        .PcPlus2(pc2_0), .dbg_state(st0)
    );

    // ---------------- DUT 1 (RESET_PC = FFFE) ----------------
    logic          req1, ack1, valid1;
    logic [W-1:0]  addr1, data1, instr1, pc2_1;
    logic [3:0]    opc1;
    logic [1:0]    st1;

    assign ack1  = req1;
    assign data1 = mem_word(addr1);

    fetch_stage #(.PC_WIDTH(W), .INSTR_WIDTH(W), .RESET_PC(16'hFFFE)) dut_wrap (
        .Clock(Clock), .Reset_n(Reset_n),
        .IMemReq(req1), .IMemAddr(addr1), .IMemAck(ack1), .IMemData(data1),
        .Stall(1'b0), .BranchTaken(1'b0), .BranchTarget(16'h0000),
        .InstrValid(valid1), .Instruction(instr1), .OPCODE(opc1),
        .PcPlus2(pc2_1), .dbg_state(st1)
    );

    // ---------------- instruction memory contents ----------------
    function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
        case (a)
            16'h0000: mem_word = 16'h1234;
            16'h0002: mem_word = 16'h9ABC;
            16'h0004: mem_word = 16'hC5A2;
            16'h0006: mem_word = 16'hD123;
            16'h0008: mem_word = 16'hE888;
            16'h0040: mem_word = 16'h7040;
            16'h0100: mem_word = 16'h3100;
            default:  mem_word = {4'hF, a[11:0]};
        endcase
    endfunction

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // advance one clock, then settle past the edge
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clock);
            #1;
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        Reset_n  = 1'b0;
        stall    = 1'b0;
        branch   = 1'b0;
        target   = '0;
        mem_auto = 1'b1;
        ack_man  = 1'b0;

        // Reset state
        step(3);
        check("rst_req",   req0,   1'b0);
        check("rst_valid", valid0, 1'b0);
        check("rst_instr", instr0, 16'h0000);
        check("rst_pc2",   pc2_0,  16'h0000);
        check("rst_addr",  addr0,  16'h0000);

        // 1: zero-wait streaming
        Reset_n = 1'b1;
        step(1);                                   // S_IDLE -> S_REQ
        check("t1_req",    req0,   1'b1);
        check("t1_addr0",  addr0,  16'h0000);
        check("t1_nv",     valid0, 1'b0);
        check("t5_addr0",  addr1,  16'hFFFE);
        step(1);
        check("t1_valid",  valid0, 1'b1);
        check("t1_opc0",   opc0,   4'h1);
        check("t1_pc2_0",  pc2_0,  16'h0002);
        check("t1_addr1",  addr0,  16'h0002);
        check("t5_addr1",  addr1,  16'h0000);
        check("t5_pc2_0",  pc2_1,  16'h0000);
        check("t5_instr",  instr1, 16'hFFFE);
        step(1);
        check("t1_opc1",   opc0,   4'h9);
        check("t1_pc2_1",  pc2_0,  16'h0004);
        check("t1_addr2",  addr0,  16'h0004);
        check("t5_pc2_1",  pc2_1,  16'h0002);
        step(1);
        check("t1_opc2",   opc0,   4'hC);
        check("t1_pc2_2",  pc2_0,  16'h0006);
        check("t1_addr3",  addr0,  16'h0006);

        // 2: ack @6 lands during a 3-cycle stall
        stall = 1'b1;
        step(1);
        check("t2_req0",   req0,   1'b0);
        check("t2_hold0",  instr0, 16'hC5A2);
        check("t2_vhold",  valid0, 1'b1);
        step(1);
        check("t2_req1",   req0,   1'b0);
        check("t2_hold1",  instr0, 16'hC5A2);
        step(1);
        check("t2_hold2",  instr0, 16'hC5A2);
        stall = 1'b0;
        step(1);
        check("t2_instr",  instr0, 16'hD123);
        check("t2_pc2",    pc2_0,  16'h0008);
        check("t2_req",    req0,   1'b1);
        check("t2_addr",   addr0,  16'h0008);

        // 3: branch during a delayed-ack request
        mem_auto = 1'b0;
        ack_man  = 1'b0;
        branch   = 1'b1;
        target   = 16'h0041;
        step(1);
        branch   = 1'b0;
        check("t3_nv",     valid0, 1'b0);
        check("t3_addr0",  addr0,  16'h0008);
        check("t3_req",    req0,   1'b1);
        step(1);
        check("t3_addr1",  addr0,  16'h0008);
        step(1);
        check("t3_addr2",  addr0,  16'h0008);
        ack_man = 1'b1;                            // stale data 16'hE888
        step(1);
        ack_man  = 1'b0;
        mem_auto = 1'b1;
        check("t3_drop_v", valid0, 1'b0);
        check("t3_newadr", addr0,  16'h0040);
        step(1);
        check("t3_instr",  instr0, 16'h7040);
        check("t3_pc2",    pc2_0,  16'h0042);
        check("t3_valid",  valid0, 1'b1);

        // 4: branch and stall together; flush wins
        branch = 1'b1;
        stall  = 1'b1;
        target = 16'h0101;
        step(1);
        check("t4_nv",     valid0, 1'b0);
        check("t4_addr",   addr0,  16'h0100);
        check("t4_req",    req0,   1'b1);
        branch = 1'b0;
        stall  = 1'b0;
        step(1);
        check("t4_instr",  instr0, 16'h3100);
        check("t4_pc2",    pc2_0,  16'h0102);

        // 6: asynchronous reset mid-request
        #2;
        Reset_n = 1'b0;
        #1;
        check("t6_req",    req0,   1'b0);
        check("t6_valid",  valid0, 1'b0);
        check("t6_instr",  instr0, 16'h0000);
        check("t6_opc",    opc0,   4'h0);
        @(posedge Clock);
        #1;
        Reset_n = 1'b1;
        check("t6_idle",   st0,    2'd0);
        step(1);
        check("t6_addr",   addr0,  16'h0000);
        check("t6_req1",   req0,   1'b1);
        check("t6_waddr",  addr1,  16'hFFFE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
